viterbi_frame_ctrl: RTL and testbench



---
 rtl/viterbi_pkg.sv | 17 +
 rtl/viterbi_dec_buf.sv | 28 ++
 rtl/viterbi_frame_ctrl.sv | 137 +++++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants and the frame controller state encoding.
// Used by the frame controller, BMC, ACS and traceback blocks.
package viterbi_pkg;

  localparam int K          = 3;
  localparam int TAIL       = K - 1;
  localparam int NUM_STATES = 4;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    TRACE,
    DRAIN,
    SEND
  } ctrl_state_t;

endpackage

// File: rtl/viterbi_dec_buf.sv
// Decoded-bit buffer: one write port, asynchronous read, cleared on reset.
// Write lands on the clock edge; read is combinational with no backpressure.
module viterbi_dec_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_dat
);

  logic [DEPTH-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Viterbi frame sequencer: accept FRAME_LEN symbol pairs, run full traceback, stream data bits.
// ACS strobe lags an accept by one cycle; in_ready drops outside RECV and out_valid holds until out_ready.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int AW        = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [1:0]    in_pair,
  output logic          in_ready,
  output logic          pm_clear,
  output logic [1:0]    bmc_pair,
  output logic          acs_en,
  output logic [AW-1:0] acs_addr,
  output logic          tb_start,
  output logic          tb_en,
  output logic [AW-1:0] tb_addr,
  input  logic          tb_bit,
  output logic          out_valid,
  output logic          out_bit,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy
);

  localparam int CW       = $clog2(FRAME_LEN + 1);
  localparam int DATA_LEN = FRAME_LEN - TAIL;
  localparam logic [CW-1:0] LAST_SYM = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(DATA_LEN - 1);
  localparam logic [AW-1:0] TOP_ADDR = AW'(FRAME_LEN - 1);

  ctrl_state_t   state, state_nxt;
  logic [CW-1:0] sym_cnt, tb_cnt, out_cnt;
  logic          accept, out_hs;
  logic          cap_vld;
  logic [AW-1:0] cap_addr;
  logic          buf_bit;

  assign accept = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    pm_clear  = 1'b0;
    tb_en     = 1'b0;
    tb_start  = 1'b0;
    tb_addr   = '0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        // Reset also parks the FSM in IDLE, so keep the pulse quiet while rst_n is low.
        pm_clear  = rst_n;
        busy      = 1'b0;
        state_nxt = RECV;
      end
      RECV: begin
        in_ready = 1'b1;
        if (in_valid && sym_cnt == LAST_SYM) state_nxt = TRACE;
      end
      TRACE: begin
        tb_en    = 1'b1;
        tb_start = (tb_cnt == '0);
        tb_addr  = TOP_ADDR - tb_cnt[AW-1:0];
        if (tb_cnt == LAST_SYM) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_bit   = buf_bit;
        out_last  = (out_cnt == LAST_OUT);
        if (out_ready && out_cnt == LAST_OUT) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt  <= '0;
      tb_cnt   <= '0;
      out_cnt  <= '0;
      bmc_pair <= '0;
      acs_en   <= 1'b0;
      acs_addr <= '0;
      cap_vld  <= 1'b0;
      cap_addr <= '0;
    end else begin
      acs_en <= accept;
      // tb_bit returns one cycle after its read, so the write address trails tb_addr by one.
      cap_vld  <= tb_en;
      cap_addr <= tb_addr;
      if (accept) begin
        bmc_pair <= in_pair;
        acs_addr <= sym_cnt[AW-1:0];
        sym_cnt  <= sym_cnt + 1'b1;
      end
      if (tb_en)  tb_cnt  <= tb_cnt + 1'b1;
      if (out_hs) out_cnt <= out_cnt + 1'b1;
      if (state == IDLE) begin
        sym_cnt <= '0;
        tb_cnt  <= '0;
        out_cnt <= '0;
      end
    end
  end

  viterbi_dec_buf #(
    .DEPTH (FRAME_LEN),
    .AW    (AW)
  ) u_dec_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cap_vld),
    .wr_addr (cap_addr),
    .wr_dat  (tb_bit),
    .rd_addr (out_cnt[AW-1:0]),
    .rd_dat  (buf_bit)
  );

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl (FRAME_LEN=8): frame-phase reference model checked every negedge,
// with randomized valid/ready/tb_bit stimulus and a few literal pins.
module tb_viterbi_frame_ctrl;

  localparam int FL = 8;
  localparam int DL = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [1:0]    in_pair;
  logic          in_ready;
  logic          pm_clear;
  logic [1:0]    bmc_pair;
  logic          acs_en;
  logic [AW-1:0] acs_addr;
  logic          tb_start;
  logic          tb_en;
  logic [AW-1:0] tb_addr;
  logic          tb_bit;
  logic          out_valid;
  logic          out_bit;
  logic          out_last;
  logic          out_ready;
  logic          busy;

  always #5 clk = ~clk;

  viterbi_frame_ctrl #(.FRAME_LEN(FL), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_pair   (in_pair),
    .in_ready  (in_ready),
    .pm_clear  (pm_clear),
    .bmc_pair  (bmc_pair),
    .acs_en    (acs_en),
    .acs_addr  (acs_addr),
    .tb_start  (tb_start),
    .tb_en     (tb_en),
    .tb_addr   (tb_addr),
    .tb_bit    (tb_bit),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 receive, 2 traceback, 3 drain, 4 send.
  int       m_phase = 0;
  int       m_rx = 0, m_tb = 0, m_out = 0, frames = 0;
  int       mode = 1;
  int       stall = 0;
  int       last_idx = 0;
  int       pend_addr = 0;
  int       f1_acs = 0;
  bit       acc_prev = 0, pend_tb = 0, v_tog = 0, b;
  bit [1:0] last_pair = 0;
  bit       exp_dec [FL];
  logic [5:0] f1_bits = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_pm_clear", pm_clear, 1'b0);
      chkw("rst_bmc_pair", 32'(bmc_pair), 32'd0);
      chk1("rst_acs_en", acs_en, 1'b0);
      chkw("rst_acs_addr", 32'(acs_addr), 32'd0);
      chk1("rst_tb_en", tb_en, 1'b0);
      chk1("rst_tb_start", tb_start, 1'b0);
      chkw("rst_tb_addr", 32'(tb_addr), 32'd0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_out_bit", out_bit, 1'b0);
      chk1("rst_out_last", out_last, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      m_phase = 0; m_rx = 0; m_tb = 0; m_out = 0; stall = 0;
      acc_prev = 0; pend_tb = 0; last_pair = 0; last_idx = 0;
      in_valid = 1'b0; in_pair = 2'b00; out_ready = 1'b0; tb_bit = 1'b0;
    end else begin
      chk1("pm_clear", pm_clear, m_phase == 0);
      chk1("busy", busy, m_phase != 0);
      chk1("in_ready", in_ready, m_phase == 1);
      chk1("tb_en", tb_en, m_phase == 2);
      chk1("tb_start", tb_start, m_phase == 2 && m_tb == 0);
      chkw("tb_addr", 32'(tb_addr), 32'(m_phase == 2 ? FL - 1 - m_tb : 0));
      chk1("out_valid", out_valid, m_phase == 4);
      chk1("out_last", out_last, m_phase == 4 && m_out == DL - 1);
      chk1("out_bit", out_bit, m_phase == 4 ? exp_dec[m_out] : 1'b0);
      chk1("acs_en", acs_en, acc_prev);
      if (acc_prev) chkw("acs_addr", 32'(acs_addr), 32'(last_idx));
      chkw("bmc_pair", 32'(bmc_pair), 32'(last_pair));
      if (frames == 0 && acs_en) f1_acs++;

      // Answer the previous cycle's traceback read.
      if (pend_tb) begin
        b = (mode == 1) ? pend_addr[0] : 1'($urandom % 2);
        exp_dec[pend_addr] = b;
        tb_bit = b;
      end else begin
        tb_bit = 1'($urandom % 2);
      end
      pend_tb   = (m_phase == 2);
      pend_addr = FL - 1 - m_tb;

      v_tog = ~v_tog;
      case (mode)
        1:       in_valid = 1'b1;
        2:       in_valid = v_tog;
        default: in_valid = 1'($urandom % 2);
      endcase
      in_pair = (mode == 1) ? 2'(m_rx % 4) : 2'($urandom % 4);
      if (mode == 3) begin
        if (m_phase == 4 && m_out == 2 && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
        end
      end else if (mode == 5) begin
        out_ready = 1'($urandom % 2);
      end else begin
        out_ready = 1'b1;
      end

      acc_prev = (m_phase == 1) && in_valid;
      if (acc_prev) begin
        last_pair = in_pair;
        last_idx  = m_rx;
      end
      case (m_phase)
        0: begin m_phase = 1; stall = 0; end
        1: if (in_valid) begin
             m_rx++;
             if (m_rx == FL) begin m_phase = 2; m_tb = 0; end
           end
        2: begin m_tb++; if (m_tb == FL) m_phase = 3; end
        3: begin m_phase = 4; m_out = 0; end
        4: if (out_ready) begin
             if (frames == 0) f1_bits[m_out] = out_bit;
             m_out++;
             if (m_out == DL) begin m_phase = 0; m_rx = 0; frames++; end
           end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic wait_frames(input int n);
    int i = 0;
    while (frames < n && i < 3000) begin
      @(posedge clk);
      i++;
    end
    chkw("frame_done", 32'(frames), 32'(n));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk1("release_pm_clear", pm_clear, 1'b1);
    chk1("release_in_ready", in_ready, 1'b0);
    @(negedge clk);
    chk1("second_in_ready", in_ready, 1'b1);
    chk1("second_pm_clear", pm_clear, 1'b0);

    wait_frames(1);
    chkw("f1_out_bits", 32'(f1_bits), 32'(6'b101010));
    chkw("f1_acs_count", 32'(f1_acs), 32'd8);

    mode = 2;
    wait_frames(2);
    mode = 3;
    wait_frames(3);

    mode = 4;
    n = 0;
    while (m_rx != 3 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chkw("reach_3_accepts", 32'(m_rx), 32'd3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_acs_en", acs_en, 1'b0);
    chkw("arst_acs_addr", 32'(acs_addr), 32'd0);
    chkw("arst_bmc_pair", 32'(bmc_pair), 32'd0);
    chk1("arst_in_ready", in_ready, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_pm_clear", pm_clear, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk1("rerelease_pm_clear", pm_clear, 1'b1);

    mode = 5;
    wait_frames(7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
